// File: rtl/vhost_defs_pkg.sv
// Shared definitions for the vhost register arbiter: data width, counter width,
// default timeout and the access state encoding.
package vhost_defs_pkg;

    localparam int DW          = 32;
    localparam int CW          = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vhost_rr_pick.sv
// Requester selector: round-robin starting after the last grant, or fixed
// priority with index 0 highest when RR is 0.
module vhost_rr_pick #(
    parameter int NREQ = 4,
    parameter int RR   = 1
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    // Both searches walk from the least preferred candidate to the most
    // preferred one, so the last hit written is the winner.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        if (RR != 0) begin
            for (int off = NREQ; off >= 1; off--) begin
                cand = IW'((int'(last) + off) % NREQ);
                if (req[cand]) idx = cand;
            end
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/vhost_reg_arb.sv
// Arbitrates NREQ register-access requesters onto a single toggle-handshake
// host model port, with a per-access timeout and a one-cycle completion pulse.
module vhost_reg_arb
    import vhost_defs_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RR      = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NREQ-1:0]    ReqValid,
    input  logic [NREQ-1:0]    ReqWE,
    input  logic [DW*NREQ-1:0] ReqAddr,
    input  logic [DW*NREQ-1:0] ReqWData,
    output logic [NREQ-1:0]    ReqDone,
    output logic               ReqErr,
    output logic [DW-1:0]      RdData,
    output logic [DW-1:0]      Addr,
    output logic               WE,
    output logic               RD,
    output logic [DW-1:0]      DataOut,
    output logic               Update,
    input  logic               UpdateResponse,
    input  logic [DW-1:0]      DataIn
);

    localparam int            IW      = $clog2(NREQ);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] gnt, last_gnt, pick_idx;
    logic          pick_any;
    logic [CW-1:0] wait_cnt;
    logic          err;
    logic          armed;
    logic          resp_match;
    logic          timed_out;
    logic [DW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = ReqAddr[i*DW +: DW];
        assign wdata_arr[i] = ReqWData[i*DW +: DW];
    end

    vhost_rr_pick #(
        .NREQ (NREQ),
        .RR   (RR)
    ) u_pick (
        .req  (ReqValid),
        .last (last_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign resp_match = (UpdateResponse == Update);
    assign timed_out  = (wait_cnt == TO_LAST);

    // NOTE: a late response after a timeout leaves UpdateResponse != Update;
    // ISSUE holds until they match so the stale toggle cannot complete the
    // next access.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (armed && pick_any)        state_nxt = ST_ISSUE;
            ST_ISSUE: if (resp_match)               state_nxt = ST_WAIT;
            ST_WAIT:  if (resp_match || timed_out)  state_nxt = ST_DONE;
            ST_DONE:                                state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            gnt      <= '0;
            last_gnt <= IW'(NREQ - 1);
            wait_cnt <= '0;
            err      <= 1'b0;
            Addr     <= '0;
            DataOut  <= '0;
            WE       <= 1'b0;
            RD       <= 1'b0;
            Update   <= 1'b0;
            RdData   <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed && pick_any) gnt <= pick_idx;
                end
                ST_ISSUE: begin
                    if (resp_match) begin
                        Addr     <= addr_arr[gnt];
                        DataOut  <= wdata_arr[gnt];
                        WE       <= ReqWE[gnt];
                        RD       <= ~ReqWE[gnt];
                        Update   <= ~Update;
                        wait_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A response in the timeout cycle still counts as success.
                    if (resp_match) begin
                        RdData <= DataIn;
                        WE     <= 1'b0;
                        RD     <= 1'b0;
                    end else if (timed_out) begin
                        err    <= 1'b1;
                        RdData <= '0;
                        WE     <= 1'b0;
                        RD     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    last_gnt <= gnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ReqDone = '0;
        if (state == ST_DONE) ReqDone[gnt] = 1'b1;
    end

    assign ReqErr = (state == ST_DONE) && err;

endmodule

// File: tb/tb_vhost_reg_arb.sv
// Directed bench: a round-robin instance driven by a scripted responder and a
// fixed-priority instance with an always-immediate responder, sharing requests.
module tb_vhost_reg_arb;

    localparam int NREQ = 4;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_we;
    logic [32*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [31:0]      data_in;

    logic [NREQ-1:0]  rr_done, fp_done;
    logic             rr_err, fp_err;
    logic [31:0]      rr_rdata, fp_rdata;
    logic [31:0]      rr_addr, fp_addr;
    logic             rr_we, fp_we, rr_rd, fp_rd;
    logic [31:0]      rr_dout, fp_dout;
    logic             rr_update, fp_update;
    logic             rr_resp, fp_resp;

    logic             resp_zero;
    logic             resp_reg;

    int checks = 0;
    int errors = 0;

    assign rr_resp = resp_zero ? rr_update : resp_reg;
    assign fp_resp = fp_update;

    vhost_reg_arb #(.NREQ(NREQ), .TIMEOUT(5), .RR(1)) u_rr (
        .Clk            (clk),
        .Reset          (reset),
        .ReqValid       (req_valid),
        .ReqWE          (req_we),
        .ReqAddr        (req_addr),
        .ReqWData       (req_wdata),
        .ReqDone        (rr_done),
        .ReqErr         (rr_err),
        .RdData         (rr_rdata),
        .Addr           (rr_addr),
        .WE             (rr_we),
        .RD             (rr_rd),
        .DataOut        (rr_dout),
        .Update         (rr_update),
        .UpdateResponse (rr_resp),
        .DataIn         (data_in)
    );

    vhost_reg_arb #(.NREQ(NREQ), .TIMEOUT(5), .RR(0)) u_fp (
        .Clk            (clk),
        .Reset          (reset),
        .ReqValid       (req_valid),
        .ReqWE          (req_we),
        .ReqAddr        (req_addr),
        .ReqWData       (req_wdata),
        .ReqDone        (fp_done),
        .ReqErr         (fp_err),
        .RdData         (fp_rdata),
        .Addr           (fp_addr),
        .WE             (fp_we),
        .RD             (fp_rd),
        .DataOut        (fp_dout),
        .Update         (fp_update),
        .UpdateResponse (fp_resp),
        .DataIn         (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rr_update(input logic exp, input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (rr_update !== exp && cyc < max);
        check("update_toggle_seen", 32'(rr_update), 32'(exp));
    endtask

    task automatic wait_rr_done(input int max, output int cyc);
        logic got;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (rr_done === '0 && cyc < max);
        got = (rr_done !== '0);
        check("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int   cyc;
        int   k;
        int   prev;
        int   fp_cnt;
        logic saved;

        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        data_in   = '0;
        resp_zero = 1'b0;
        resp_reg  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_done",   32'(rr_done),  32'd0);
        check("rst_err",    32'(rr_err),   32'd0);
        check("rst_rdata",  rr_rdata,      32'd0);
        check("rst_addr",   rr_addr,       32'd0);
        check("rst_we_rd",  32'({rr_we, rr_rd}), 32'd0);
        check("rst_dout",   rr_dout,       32'd0);
        check("rst_update", 32'(rr_update), 32'd0);
        reset = 1'b0;
        tick();

        // Single read, responder answers two cycles after the toggle
        req_valid = 4'b0001;
        req_addr[31:0] = 32'h10;
        wait_rr_update(1'b1, 10, cyc);
        check("rd_strobe", 32'({rr_we, rr_rd}), 32'd1);
        check("rd_addr",   rr_addr, 32'h10);
        tick();
        tick();
        check("rd_no_early_done", 32'(rr_done), 32'd0);
        resp_reg = rr_update;
        data_in  = 32'hCAFE;
        wait_rr_done(10, cyc);
        check("rd_done_latency", 32'(cyc), 32'd1);
        check("rd_done",  32'(rr_done), 32'b0001);
        check("rd_err",   32'(rr_err),  32'd0);
        check("rd_rdata", rr_rdata,     32'hCAFE);
        check("rd_strobe_off", 32'({rr_we, rr_rd}), 32'd0);
        req_valid = '0;
        tick();
        check("rd_done_pulse", 32'(rr_done), 32'd0);

        // All four requesters held, immediate responder; RR and fixed priority
        reset     = 1'b1;
        resp_zero = 1'b1;
        data_in   = 32'h1234;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[32*i +: 32]  = 32'h100 + 32'(i);
            req_wdata[32*i +: 32] = 32'hA0 + 32'(i);
        end
        req_valid = 4'b1111;
        k      = 0;
        prev   = 0;
        fp_cnt = 0;
        cyc    = 0;
        while (k < 5 && cyc < 60) begin
            tick();
            cyc++;
            check("we_rd_exclusive", 32'({rr_we & rr_rd, fp_we & fp_rd}), 32'd0);
            if (rr_done !== '0) begin
                check("rr_grant_order", 32'(rr_done), 32'd1 << (k % 4));
                check("rr_rdata", rr_rdata, 32'h1234);
                if (k > 0) check("rr_grant_gap", 32'(cyc - prev), 32'd4);
                prev = cyc;
                k++;
            end
            if (fp_done !== '0) begin
                check("fp_grant_zero", 32'(fp_done), 32'b0001);
                check("fp_err", 32'(fp_err), 32'd0);
                fp_cnt++;
            end
        end
        check("rr_grant_count", 32'(k), 32'd5);
        check("fp_grant_count", 32'(fp_cnt), 32'd5);
        check("fp_addr",  fp_addr,  32'h100);
        check("fp_dout",  fp_dout,  32'hA0);
        check("fp_rdata", fp_rdata, 32'h1234);
        req_valid = '0;

        // Write with silent responder: timeout after 5 WAIT cycles
        resp_reg  = rr_update;
        resp_zero = 1'b0;
        tick();
        req_valid = 4'b0100;
        req_we    = 4'b0100;
        req_addr[95:64]  = 32'h20;
        req_wdata[95:64] = 32'hDEADBEEF;
        data_in = 32'h5555;
        saved = rr_update;
        wait_rr_update(~saved, 10, cyc);
        check("wr_strobe", 32'({rr_we, rr_rd}), 32'd2);
        check("wr_addr",   rr_addr, 32'h20);
        check("wr_dout",   rr_dout, 32'hDEADBEEF);
        wait_rr_done(20, cyc);
        check("to_wait_cycles", 32'(cyc), 32'd5);
        check("to_done",  32'(rr_done), 32'b0100);
        check("to_err",   32'(rr_err),   32'd1);
        check("to_rdata", rr_rdata,      32'd0);

        // Next request must stall until the late toggle arrives
        req_valid = 4'b0001;
        req_we    = '0;
        req_addr[31:0] = 32'h44;
        saved = rr_update;
        tick();
        tick();
        tick();
        check("late_update_held", 32'(rr_update), 32'(saved));
        check("late_no_strobe",   32'({rr_we, rr_rd, rr_done}), 32'd0);
        resp_reg = rr_update;
        wait_rr_update(~saved, 4, cyc);
        check("late_issue_latency", 32'(cyc), 32'd1);
        check("late_rd_addr", rr_addr, 32'h44);
        resp_reg = rr_update;
        data_in  = 32'h77;
        wait_rr_done(10, cyc);
        check("late_done",  32'(rr_done), 32'b0001);
        check("late_err",   32'(rr_err),  32'd0);
        check("late_rdata", rr_rdata,     32'h77);
        req_valid = '0;
        tick();

        // Response arriving in the exact timeout cycle wins
        req_valid = 4'b0010;
        req_addr[63:32] = 32'h30;
        saved = rr_update;
        wait_rr_update(~saved, 10, cyc);
        tick();
        tick();
        tick();
        tick();
        check("edge_no_early_done", 32'(rr_done), 32'd0);
        resp_reg = rr_update;
        data_in  = 32'hBEEF;
        tick();
        check("edge_done",  32'(rr_done), 32'b0010);
        check("edge_err",   32'(rr_err),  32'd0);
        check("edge_rdata", rr_rdata,     32'hBEEF);
        req_valid = '0;
        tick();

        // Reset during WAIT
        req_valid = 4'b1000;
        req_addr[127:96] = 32'h40;
        saved = rr_update;
        wait_rr_update(~saved, 10, cyc);
        tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_addr",  rr_addr,  32'd0);
        check("mid_rst_dout",  rr_dout,  32'd0);
        check("mid_rst_rdata", rr_rdata, 32'd0);
        check("mid_rst_ctl",   32'({rr_we, rr_rd, rr_err, rr_update, rr_done}), 32'd0);
        resp_reg = 1'b0;
        tick();
        tick();
        check("mid_rst_no_done", 32'(rr_done), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_no_early_issue", 32'(rr_update), 32'd0);
        wait_rr_update(1'b1, 4, cyc);
        check("post_rst_issue_latency", 32'(cyc), 32'd1);
        resp_reg = 1'b1;
        data_in  = 32'h3333;
        wait_rr_done(10, cyc);
        check("post_rst_done",  32'(rr_done), 32'b1000);
        check("post_rst_err",   32'(rr_err),  32'd0);
        check("post_rst_rdata", rr_rdata,     32'h3333);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
